// File: rtl/imem_responder.sv
// Instruction memory responder: 2^ADDR_W x 32 RAM read by fetch after WAIT_CYCLES extra cycles.
// Latency WAIT_CYCLES+1 cycles; busy stalls fetch, requests while busy are dropped, flush cancels.
module imem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    input  logic              req_valid,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    output logic              busy,
    output logic              fault
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_pc_q;
    logic        valid_q, fault_q;
    logic        accept, fire;
    logic [31:0] rd_pc;
    logic [ADDR_W-1:0] rd_idx;
    logic        rd_fault;

    logic [31:0] mem [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        fire    = 1'b0;
        accept  = req_valid && !flush && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pc_d = pc;
                    if (WAIT_CYCLES == 0) begin
                        fire = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything, including a response due at this edge.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            fire    = 1'b0;
        end
    end

    // With no wait states the response is issued at the accepting edge, so read from the live pc.
    assign rd_pc    = (WAIT_CYCLES == 0) ? pc : pc_q;
    assign rd_idx   = rd_pc[ADDR_W+1:2];
    assign rd_fault = (rd_pc[1:0] != 2'b00) || ((rd_pc >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            pc_q       <= 32'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= fire;
            if (fire) begin
                instr_q    <= rd_fault ? 32'd0 : mem[rd_idx];
                instr_pc_q <= rd_pc;
                fault_q    <= rd_fault;
            end
        end
    end

    // Nonblocking write alongside the read above gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (rst_n && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign busy        = (state_q == S_WAIT);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic against a request-level model.
module tb_imem_responder;

    localparam int AW    = 10;
    localparam int WT    = 2;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc = '0;
    logic          req_valid = 1'b0;
    logic          flush = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;

    logic [31:0] instr, instr_pc, instr0, instr_pc0;
    logic        instr_valid, busy, fault, instr_valid0, busy0, fault0;

    int n_cmp = 0;
    int n_bad = 0;

    imem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WT)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .req_valid(req_valid), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .busy(busy), .fault(fault));

    imem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .req_valid(req_valid), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr0), .instr_pc(instr_pc0), .instr_valid(instr_valid0), .busy(busy0), .fault(fault0));

    always #5 clk = ~clk;

    // Request-level model: one outstanding request due WT edges after it was accepted.
    logic [31:0] m_mem [DEPTH];
    int          edge_n = 0;
    bit          pend = 0;
    int          due = 0;
    logic [31:0] ppc = '0;
    logic        e_valid = 0, e_fault = 0, e0_valid = 0, e0_fault = 0;
    logic [31:0] e_instr = '0, e_pc = '0, e0_instr = '0, e0_pc = '0;

    function automatic bit is_bad(input logic [31:0] p);
        return (p % 4 != 0) || (p >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] p);
        return is_bad(p) ? 32'd0 : m_mem[p / 4];
    endfunction

    task automatic cyc();
        @(posedge clk);
        edge_n++;
        e_valid  = 1'b0;
        e0_valid = 1'b0;
        if (!rst_n) begin
            pend = 0;
            e_instr = '0; e_pc = '0; e_fault = 0;
            e0_instr = '0; e0_pc = '0; e0_fault = 0;
        end else begin
            if (flush) begin
                pend = 0;
            end else if (pend && edge_n == due) begin
                e_valid = 1; e_pc = ppc; e_fault = is_bad(ppc); e_instr = rd_word(ppc);
                pend = 0;
            end else if (!pend && req_valid) begin
                ppc = pc; due = edge_n + WT; pend = 1;
            end
            if (req_valid && !flush) begin
                e0_valid = 1; e0_pc = pc; e0_fault = is_bad(pc); e0_instr = rd_word(pc);
            end
            if (prog_we) m_mem[prog_addr] = prog_data;
        end
        #1;
    endtask

    task automatic set_req(input logic r, input logic [31:0] p, input logic f);
        req_valid = r; pc = p; flush = f;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_req(1, 32'h8, 0);
        cyc(); cyc();
        n_cmp += 6;
        if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (instr !== 32'd0) begin n_bad++; $display("FAIL rst_instr got %h exp 0", instr); end
        if (instr_pc !== 32'd0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", instr_pc); end
        if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b exp 0", fault); end
        if (instr_valid0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid0 got %b exp 0", instr_valid0); end
        set_req(0, 0, 0);
        rst_n = 1;
        cyc();
    endtask

    task automatic load_mem();
        prog_we = 1;
        for (int i = 0; i < DEPTH; i++) begin
            prog_addr = AW'(i);
            prog_data = (i < 4) ? 32'(8'h11 * (i + 1)) : $urandom;
            cyc();
        end
        prog_we = 0;
        cyc();
    endtask

    task automatic test_basic();
        set_req(1, 32'h8, 0);
        cyc();
        set_req(0, 0, 0);
        n_cmp += 2;
        if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_t1 busy %b valid %b exp 1/0", busy, instr_valid); end
        cyc();
        if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_t2 busy %b valid %b exp 1/0", busy, instr_valid); end
        cyc();
        n_cmp += 3;
        if (instr_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_t3 valid %b busy %b exp 1/0", instr_valid, busy); end
        if (instr !== 32'h33 || instr_pc !== 32'h8) begin n_bad++; $display("FAIL basic_data instr %h pc %h exp 33/8", instr, instr_pc); end
        if (fault !== 1'b0) begin n_bad++; $display("FAIL basic_fault got %b exp 0", fault); end
        cyc();
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h33) begin n_bad++; $display("FAIL basic_hold valid %b instr %h exp 0/33", instr_valid, instr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [$];
        int          at  [$];
        int          nacc = 0;
        logic        pre_busy;
        set_req(1, 32'h0, 0);
        for (int c = 0; c < 10; c++) begin
            pre_busy = busy;
            cyc();
            if (req_valid && !pre_busy) begin
                nacc++;
                if (nacc == 2) set_req(0, 0, 0); else pc = pc + 4;
            end
            if (instr_valid) begin got.push_back(instr); at.push_back(c); end
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_bad++; $display("FAIL b2b_count got %0d exp 2", got.size());
        end else begin
            n_cmp += 3;
            if (got[0] !== 32'h11) begin n_bad++; $display("FAIL b2b_first got %h exp 11", got[0]); end
            if (got[1] !== 32'h22) begin n_bad++; $display("FAIL b2b_second got %h exp 22", got[1]); end
            if (at[1] - at[0] != 3) begin n_bad++; $display("FAIL b2b_spacing got %0d exp 3", at[1] - at[0]); end
        end
    endtask

    task automatic test_flush();
        set_req(1, 32'h4, 0);
        cyc();
        set_req(0, 0, 1);
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cancel busy %b valid %b exp 0/0", busy, instr_valid); end
        set_req(1, 32'hC, 0);
        cyc();
        set_req(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_novalid%0d got %b exp 0", i, instr_valid); end
            cyc();
        end
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h44 || instr_pc !== 32'hC) begin
            n_bad++; $display("FAIL flush_next valid %b instr %h pc %h exp 1/44/c", instr_valid, instr, instr_pc);
        end
        set_req(1, 32'h0, 0);
        cyc();
        set_req(0, 0, 0);
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h44) begin n_bad++; $display("FAIL flush_fire valid %b instr %h exp 0/44", instr_valid, instr); end
        cyc();
        n_cmp++;
        if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_late got %b exp 0", instr_valid); end
    endtask

    task automatic test_fault();
        logic [31:0] pcs [2];
        pcs[0] = 32'h6;
        pcs[1] = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            set_req(1, pcs[k], 0);
            cyc();
            set_req(0, 0, 0);
            cyc(); cyc();
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== 32'd0 || fault !== 1'b1 || instr_pc !== pcs[k]) begin
                n_bad++;
                $display("FAIL fault_%0d valid %b instr %h fault %b pc %h exp 1/0/1/%h", k, instr_valid, instr, fault, instr_pc, pcs[k]);
            end
            cyc();
        end
    endtask

    task automatic test_reset_wait();
        set_req(1, 32'h8, 0);
        cyc();
        set_req(0, 0, 0);
        rst_n = 0;
        prog_we = 1; prog_addr = 2; prog_data = 32'hDEAD_BEEF;
        cyc();
        rst_n = 1;
        prog_we = 0;
        n_cmp++;
        if ({instr_valid, busy, fault} !== 3'b000 || instr !== 32'd0 || instr_pc !== 32'd0) begin
            n_bad++; $display("FAIL rstw_outputs valid %b busy %b fault %b instr %h pc %h exp zeros", instr_valid, busy, fault, instr, instr_pc);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_novalid%0d got %b exp 0", i, instr_valid); end
        end
        set_req(1, 32'h8, 0);
        cyc();
        set_req(0, 0, 0);
        cyc(); cyc();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h33) begin n_bad++; $display("FAIL rstw_mem valid %b instr %h exp 1/33", instr_valid, instr); end
    endtask

    task automatic test_zero_wait();
        cyc(); cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 32'(4 * i), 0);
            cyc();
            n_cmp++;
            if (instr_valid0 !== 1'b1 || busy0 !== 1'b0 || instr0 !== 32'(8'h11 * (i + 1)) || instr_pc0 !== 32'(4 * i)) begin
                n_bad++;
                $display("FAIL zw_%0d valid %b busy %b instr %h pc %h exp 1/0/%h/%h", i, instr_valid0, busy0, instr0, instr_pc0, 8'h11 * (i + 1), 4 * i);
            end
        end
        set_req(0, 0, 0);
        cyc();
        n_cmp++;
        if (instr_valid0 !== 1'b0 || busy0 !== 1'b0) begin n_bad++; $display("FAIL zw_idle valid %b busy %b exp 0/0", instr_valid0, busy0); end
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 600; c++) begin
            sel = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 9) < 7);
            pc = (sel == 0) ? 32'($urandom_range(0, 63) | 1) :
                 (sel == 1) ? (($urandom | 32'h1000) & ~32'h3) : 32'($urandom_range(0, 15) * 4);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            prog_we = ($urandom_range(0, 4) == 0);
            prog_addr = AW'($urandom_range(0, 15));
            prog_data = $urandom;
            cyc();
            n_cmp += 2;
            if (instr_valid !== e_valid || busy !== pend || instr !== e_instr || instr_pc !== e_pc || fault !== e_fault) begin
                n_bad++;
                $display("FAIL rnd_w2 c%0d got v%b b%b i%h p%h f%b exp v%b b%b i%h p%h f%b", c,
                         instr_valid, busy, instr, instr_pc, fault, e_valid, pend, e_instr, e_pc, e_fault);
            end
            if (instr_valid0 !== e0_valid || busy0 !== 1'b0 || instr0 !== e0_instr || instr_pc0 !== e0_pc || fault0 !== e0_fault) begin
                n_bad++;
                $display("FAIL rnd_w0 c%0d got v%b b%b i%h p%h f%b exp v%b b0 i%h p%h f%b", c,
                         instr_valid0, busy0, instr0, instr_pc0, fault0, e0_valid, e0_instr, e0_pc, e0_fault);
            end
        end
        rst_n = 1; prog_we = 0;
        set_req(0, 0, 0);
    endtask

    initial begin
        test_reset();
        load_mem();
        test_basic();
        test_back_to_back();
        test_flush();
        test_fault();
        test_reset_wait();
        test_zero_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
